rd_arbiter: RTL and testbench

RD_ARBITER -- requirements
Module: rd_arbiter

---
 rtl/rd_arbiter.sv | 167 ++++++++++++++++
 tb/tb_rd_arbiter.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rd_arbiter.sv
// Two-master round-robin read arbiter in front of a single slave port.
// One transaction in flight; a BUSY watchdog turns a silent slave into an error response.
module rd_arbiter #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned DATA_W  = 32,
    parameter int unsigned TIMEOUT = 256
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              m0_req,
    input  logic [ADDR_W-1:0] m0_addr,
    output logic [DATA_W-1:0] m0_rdata,
    output logic [1:0]        m0_resp,
    output logic              m0_ack,

    input  logic              m1_req,
    input  logic [ADDR_W-1:0] m1_addr,
    output logic [DATA_W-1:0] m1_rdata,
    output logic [1:0]        m1_resp,
    output logic              m1_ack,

    output logic              s_req,
    output logic [ADDR_W-1:0] s_addr,
    input  logic [DATA_W-1:0] s_rdata,
    input  logic [1:0]        s_resp,
    input  logic              s_ack
);

    // Keep the counter at least one bit wide so TIMEOUT=0 still elaborates.
    localparam int unsigned CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
    localparam logic [1:0] RESP_ABORT = 2'b11;

    typedef enum logic [1:0] {
        StIdle,
        StBusy,
        StAbort
    } state_e;

    state_e            state_q, state_d;
    logic              grant_q, grant_d;
    logic              last_grant_q, last_grant_d;
    logic              s_req_q, s_req_d;
    logic [ADDR_W-1:0] s_addr_q, s_addr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic winner;
    logic timeout_hit;
    logic done;
    logic abort;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= StIdle;
            grant_q      <= 1'b0;
            last_grant_q <= 1'b1;
            s_req_q      <= 1'b0;
            s_addr_q     <= '0;
            cnt_q        <= '0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            s_req_q      <= s_req_d;
            s_addr_q     <= s_addr_d;
            cnt_q        <= cnt_d;
        end
    end

    // On a tie the master that did not win last time gets the slot.
    always_comb begin
        if (m0_req && m1_req) begin
            winner = ~last_grant_q;
        end else begin
            winner = m1_req;
        end
    end

    assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST);

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        s_req_d      = s_req_q;
        s_addr_d     = s_addr_q;
        cnt_d        = cnt_q;

        unique case (state_q)
            StIdle: begin
                if (m0_req || m1_req) begin
                    state_d      = StBusy;
                    grant_d      = winner;
                    last_grant_d = winner;
                    s_req_d      = 1'b1;
                    s_addr_d     = winner ? m1_addr : m0_addr;
                    cnt_d        = '0;
                end
            end
            StBusy: begin
                // A slave ack in the final allowed cycle still completes normally.
                if (s_ack) begin
                    state_d = StIdle;
                    s_req_d = 1'b0;
                end else begin
                    if (TIMEOUT != 0) begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                    if (timeout_hit) begin
                        state_d = StAbort;
                        s_req_d = 1'b0;
                    end
                end
            end
            StAbort: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
                s_req_d = 1'b0;
            end
        endcase
    end

    assign done  = (state_q == StBusy) && s_ack;
    assign abort = (state_q == StAbort);

    always_comb begin
        m0_ack   = 1'b0;
        m0_rdata = '0;
        m0_resp  = 2'b00;
        m1_ack   = 1'b0;
        m1_rdata = '0;
        m1_resp  = 2'b00;

        if (done) begin
            if (grant_q) begin
                m1_ack   = 1'b1;
                m1_rdata = s_rdata;
                m1_resp  = s_resp;
            end else begin
                m0_ack   = 1'b1;
                m0_rdata = s_rdata;
                m0_resp  = s_resp;
            end
        end else if (abort) begin
            if (grant_q) begin
                m1_ack  = 1'b1;
                m1_resp = RESP_ABORT;
            end else begin
                m0_ack  = 1'b1;
                m0_resp = RESP_ABORT;
            end
        end
    end

    assign s_req  = s_req_q;
    assign s_addr = s_addr_q;

`ifndef SYNTHESIS
    a_ack_exclusive : assert property (@(posedge clk) disable iff (rst) !(m0_ack && m1_ack));
    a_req_in_busy : assert property (@(posedge clk) disable iff (rst)
        s_req == (state_q == StBusy));
`endif

endmodule

// File: tb/tb_rd_arbiter.sv
// Directed bench for rd_arbiter with TIMEOUT=4: single read, ties, timeout, boundary, reset.
module tb_rd_arbiter;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              m0_req, m1_req;
    logic [ADDR_W-1:0] m0_addr, m1_addr;
    logic [DATA_W-1:0] m0_rdata, m1_rdata;
    logic [1:0]        m0_resp, m1_resp;
    logic              m0_ack, m1_ack;
    logic              s_req;
    logic [ADDR_W-1:0] s_addr;
    logic [DATA_W-1:0] s_rdata;
    logic [1:0]        s_resp;
    logic              s_ack;

    int checks = 0;
    int passes = 0;

    rd_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(4)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .m0_req  (m0_req),
        .m0_addr (m0_addr),
        .m0_rdata(m0_rdata),
        .m0_resp (m0_resp),
        .m0_ack  (m0_ack),
        .m1_req  (m1_req),
        .m1_addr (m1_addr),
        .m1_rdata(m1_rdata),
        .m1_resp (m1_resp),
        .m1_ack  (m1_ack),
        .s_req   (s_req),
        .s_addr  (s_addr),
        .s_rdata (s_rdata),
        .s_resp  (s_resp),
        .s_ack   (s_ack)
    );

    always #5 clk = ~clk;

    // Inputs change 1 ns after the rising edge; outputs are sampled 1 ns after that.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; m0_req = 1'b0; m1_req = 1'b0; m0_addr = '0; m1_addr = '0;
        s_rdata = 32'h1234_5678; s_resp = 2'b01; s_ack = 1'b1;
        step(); step();
        #1;
        checks++; if (s_req !== 1'b0) $display("FAIL reset s_req: got %0b want 0", s_req);
        else passes++;
        checks++; if (s_addr !== 32'h0) $display("FAIL reset s_addr: got %h want 0", s_addr);
        else passes++;
        checks++;
        if (m0_ack !== 1'b0 || m0_rdata !== 32'h0 || m0_resp !== 2'b00)
            $display("FAIL reset m0 outs: got ack=%0b rdata=%h resp=%0d want 0/0/0",
                     m0_ack, m0_rdata, m0_resp);
        else passes++;
        checks++;
        if (m1_ack !== 1'b0 || m1_rdata !== 32'h0 || m1_resp !== 2'b00)
            $display("FAIL reset m1 outs: got ack=%0b rdata=%h resp=%0d want 0/0/0",
                     m1_ack, m1_rdata, m1_resp);
        else passes++;
        s_ack = 1'b0; s_rdata = '0; s_resp = 2'b00;
        @(negedge clk);
        rst = 1'b0;
        step();
    endtask

    task automatic test_tie();
        // N: both request right after reset -> master 0 wins.
        m0_req = 1'b1; m0_addr = 32'h0000_00A0;
        m1_req = 1'b1; m1_addr = 32'h0000_00B0;
        step();
        #1;
        checks++; if (s_addr !== 32'hA0) $display("FAIL tie1 s_addr: got %h want a0", s_addr);
        else passes++;
        step();
        s_ack = 1'b1; s_rdata = 32'h1111_1111; s_resp = 2'b01;
        #1;
        checks++;
        if (m0_ack !== 1'b1 || m0_rdata !== 32'h1111_1111 || m0_resp !== 2'b01)
            $display("FAIL tie1 m0 ack: got ack=%0b rdata=%h resp=%0d want 1/11111111/1",
                     m0_ack, m0_rdata, m0_resp);
        else passes++;
        checks++;
        if (m1_ack !== 1'b0 || m1_rdata !== 32'h0 || m1_resp !== 2'b00)
            $display("FAIL tie1 m1 isolation: got ack=%0b rdata=%h resp=%0d want 0/0/0",
                     m1_ack, m1_rdata, m1_resp);
        else passes++;
        step();
        m0_req = 1'b0; s_ack = 1'b0;
        #1;
        checks++; if (s_req !== 1'b0) $display("FAIL tie gap s_req: got %0b want 0", s_req);
        else passes++;
        step();
        #1;
        checks++;
        if (s_req !== 1'b1 || s_addr !== 32'hB0)
            $display("FAIL tie2 grant m1: got s_req=%0b s_addr=%h want 1/b0", s_req, s_addr);
        else passes++;
        step();
        s_ack = 1'b1; s_rdata = 32'h2222_2222; s_resp = 2'b10;
        #1;
        checks++;
        if (m1_ack !== 1'b1 || m1_rdata !== 32'h2222_2222 || m1_resp !== 2'b10)
            $display("FAIL tie2 m1 ack: got ack=%0b rdata=%h resp=%0d want 1/22222222/2",
                     m1_ack, m1_rdata, m1_resp);
        else passes++;
        checks++;
        if (m0_ack !== 1'b0 || m0_rdata !== 32'h0)
            $display("FAIL tie2 m0 isolation: got ack=%0b rdata=%h want 0/0", m0_ack, m0_rdata);
        else passes++;
        step();
        // Second tie: master 1 was last, so master 0 wins again.
        s_ack = 1'b0; m0_req = 1'b1; m1_req = 1'b1;
        step();
        #1;
        checks++; if (s_addr !== 32'hA0) $display("FAIL tie3 s_addr: got %h want a0", s_addr);
        else passes++;
        s_ack = 1'b1; s_rdata = 32'h3333_3333; s_resp = 2'b00;
        #1;
        checks++;
        if (m0_ack !== 1'b1 || m1_ack !== 1'b0)
            $display("FAIL tie3 acks: got m0=%0b m1=%0b want 1/0", m0_ack, m1_ack);
        else passes++;
        step();
        s_ack = 1'b0; m0_req = 1'b0; m1_req = 1'b0;
        step();
    endtask

    task automatic test_single_read();
        m0_req = 1'b1; m0_addr = 32'h0000_0100;
        #1;
        checks++; if (s_req !== 1'b0) $display("FAIL single n s_req: got %0b want 0", s_req);
        else passes++;
        for (int i = 1; i <= 2; i++) begin
            step();
            #1;
            checks++;
            if (s_req !== 1'b1 || s_addr !== 32'h100 || m0_ack !== 1'b0)
                $display("FAIL single n+%0d: got s_req=%0b s_addr=%h ack=%0b want 1/100/0",
                         i, s_req, s_addr, m0_ack);
            else passes++;
        end
        step();
        s_ack = 1'b1; s_rdata = 32'hDEAD_BEEF; s_resp = 2'b00;
        #1;
        checks++;
        if (s_req !== 1'b1 || m0_ack !== 1'b1 || m0_rdata !== 32'hDEAD_BEEF || m0_resp !== 2'b00)
            $display("FAIL single n+3: got s_req=%0b ack=%0b rdata=%h resp=%0d want 1/1/deadbeef/0",
                     s_req, m0_ack, m0_rdata, m0_resp);
        else passes++;
        step();
        s_ack = 1'b0; m0_req = 1'b0;
        #1;
        checks++;
        if (s_req !== 1'b0 || m0_ack !== 1'b0)
            $display("FAIL single n+4: got s_req=%0b ack=%0b want 0/0", s_req, m0_ack);
        else passes++;
        step();
    endtask

    task automatic test_timeout();
        m1_req = 1'b1; m1_addr = 32'h0000_0300; s_rdata = 32'h5555_AAAA; s_resp = 2'b01;
        for (int i = 1; i <= 4; i++) begin
            step();
            #1;
            checks++;
            if (s_req !== 1'b1 || s_addr !== 32'h300 || m1_ack !== 1'b0)
                $display("FAIL timeout busy%0d: got s_req=%0b s_addr=%h ack=%0b want 1/300/0",
                         i, s_req, s_addr, m1_ack);
            else passes++;
        end
        step();
        #1;
        checks++;
        if (s_req !== 1'b0 || m1_ack !== 1'b1 || m1_resp !== 2'b11 || m1_rdata !== 32'h0)
            $display("FAIL timeout abort: got s_req=%0b ack=%0b resp=%0d rdata=%h want 0/1/3/0",
                     s_req, m1_ack, m1_resp, m1_rdata);
        else passes++;
        checks++; if (m0_ack !== 1'b0) $display("FAIL timeout m0 ack: got %0b want 0", m0_ack);
        else passes++;
        step();
        m1_req = 1'b0; s_ack = 1'b1;
        #1;
        checks++;
        if (m0_ack !== 1'b0 || m1_ack !== 1'b0 || m1_resp !== 2'b00)
            $display("FAIL timeout late ack: got m0=%0b m1=%0b resp=%0d want 0/0/0",
                     m0_ack, m1_ack, m1_resp);
        else passes++;
        step();
        s_ack = 1'b0;
        #1;
        checks++; if (s_req !== 1'b0) $display("FAIL timeout idle s_req: got %0b want 0", s_req);
        else passes++;
        step();
    endtask

    task automatic test_boundary();
        m0_req = 1'b1; m0_addr = 32'h0000_0400;
        step(); step(); step();
        #1;
        checks++;
        if (s_req !== 1'b1 || m0_ack !== 1'b0)
            $display("FAIL boundary busy3: got s_req=%0b ack=%0b want 1/0", s_req, m0_ack);
        else passes++;
        step();
        s_ack = 1'b1; s_rdata = 32'hCAFE_F00D; s_resp = 2'b01;
        #1;
        checks++;
        if (m0_ack !== 1'b1 || m0_rdata !== 32'hCAFE_F00D || m0_resp !== 2'b01)
            $display("FAIL boundary ack: got ack=%0b rdata=%h resp=%0d want 1/cafef00d/1",
                     m0_ack, m0_rdata, m0_resp);
        else passes++;
        step();
        s_ack = 1'b0; m0_req = 1'b0;
        #1;
        checks++;
        if (m0_ack !== 1'b0 || m0_resp !== 2'b00 || s_req !== 1'b0)
            $display("FAIL boundary no abort: got ack=%0b resp=%0d s_req=%0b want 0/0/0",
                     m0_ack, m0_resp, s_req);
        else passes++;
        step();
    endtask

    task automatic test_reset_mid();
        m1_req = 1'b1; m1_addr = 32'h0000_0500;
        step();
        #1;
        checks++; if (s_req !== 1'b1) $display("FAIL rstmid busy s_req: got %0b want 1", s_req);
        else passes++;
        step();
        #2;
        rst = 1'b1; s_ack = 1'b1; s_rdata = 32'h7777_7777;
        #1;
        checks++;
        if (s_req !== 1'b0 || s_addr !== 32'h0)
            $display("FAIL rstmid async drop: got s_req=%0b s_addr=%h want 0/0", s_req, s_addr);
        else passes++;
        checks++;
        if (m0_ack !== 1'b0 || m1_ack !== 1'b0 || m1_rdata !== 32'h0)
            $display("FAIL rstmid no ack: got m0=%0b m1=%0b rdata=%h want 0/0/0",
                     m0_ack, m1_ack, m1_rdata);
        else passes++;
        m1_req = 1'b0; s_ack = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        step();
        m0_req = 1'b1; m0_addr = 32'h0000_0600;
        m1_req = 1'b1; m1_addr = 32'h0000_0700;
        step();
        #1;
        checks++;
        if (s_req !== 1'b1 || s_addr !== 32'h600)
            $display("FAIL rstmid tie: got s_req=%0b s_addr=%h want 1/600", s_req, s_addr);
        else passes++;
        s_ack = 1'b1; s_rdata = 32'h8888_8888; s_resp = 2'b00;
        #1;
        checks++;
        if (m0_ack !== 1'b1 || m1_ack !== 1'b0)
            $display("FAIL rstmid tie ack: got m0=%0b m1=%0b want 1/0", m0_ack, m1_ack);
        else passes++;
        step();
        s_ack = 1'b0; m0_req = 1'b0; m1_req = 1'b0;
        step();
    endtask

    initial begin
        test_reset();
        test_tie();
        test_single_read();
        test_timeout();
        test_boundary();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
